// File: rtl/regfile.sv
// regfile -- 32 x 32-bit register file with a per-register scoreboard.
//
// Two asynchronous read ports (rs/rt), one write-back port, and a busy
// bit per register tracking issued-but-not-yet-written-back destinations.
// Register 0 reads as zero and its busy bit is always clear.
//
// Ports:
//   clk            rising-edge clock for all state
//   rstn           asynchronous active-low reset (clears data and busy)
//   stall          freezes all state updates (writes and scoreboard)
//   reg_write_en   write-back strobe
//   reg_write_addr write-back destination register
//   reg_write_data write-back data
//   rs_addr/rt_addr read port addresses
//   rs_data/rt_data read port data (combinational)
//   issue_valid    instruction with a register destination issuing now
//   issue_dst      destination of the issuing instruction
//   rs_busy/rt_busy outstanding-write flag for rs_addr/rt_addr
//
// Configuration:
//   REGFILE_BYPASS_EN  when defined, a same-cycle committing write is
//                      forwarded to the read ports and hides the busy flag
//                      of the register being written (unless it is being
//                      re-issued in the same cycle).
module regfile (
  input  logic        clk,
  input  logic        rstn,
  input  logic        stall,
  input  logic        reg_write_en,
  input  logic [4:0]  reg_write_addr,
  input  logic [31:0] reg_write_data,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data,
  input  logic        issue_valid,
  input  logic [4:0]  issue_dst,
  output logic        rs_busy,
  output logic        rt_busy
);

  logic [31:0] regs [32];
  logic [31:0] busy;
  logic [31:0] busy_next;
  logic        wr_fire;
  logic        iss_fire;

  assign wr_fire  = reg_write_en && (reg_write_addr != '0) && !stall;
  assign iss_fire = issue_valid  && (issue_dst      != '0) && !stall;

  // Data storage; entry 0 is never written so it stays zero.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      regs <= '{default: '0};
    end else if (wr_fire) begin
      regs[reg_write_addr] <= reg_write_data;
    end
  end

  // Scoreboard: clear is applied first so a same-register set wins.
  always_comb begin
    busy_next = busy;
    if (wr_fire)  busy_next[reg_write_addr] = 1'b0;
    if (iss_fire) busy_next[issue_dst]      = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic byp_rs;
  logic byp_rt;

  // rstn gate keeps the forwarded value from leaking out during reset.
  assign byp_rs = rstn && wr_fire && (rs_addr == reg_write_addr);
  assign byp_rt = rstn && wr_fire && (rt_addr == reg_write_addr);

  always_comb begin
    rs_data = (rs_addr == '0) ? '0 : regs[rs_addr];
    rt_data = (rt_addr == '0) ? '0 : regs[rt_addr];
    rs_busy = busy[rs_addr];
    rt_busy = busy[rt_addr];
    if (byp_rs) begin
      rs_data = reg_write_data;
      rs_busy = iss_fire && (issue_dst == rs_addr);
    end
    if (byp_rt) begin
      rt_data = reg_write_data;
      rt_busy = iss_fire && (issue_dst == rt_addr);
    end
  end
`else
  always_comb begin
    rs_data = (rs_addr == '0) ? '0 : regs[rs_addr];
    rt_data = (rt_addr == '0) ? '0 : regs[rt_addr];
    rs_busy = busy[rs_addr];
    rt_busy = busy[rt_addr];
  end
`endif

endmodule

// File: tb/tb_regfile.sv
module tb_regfile;

  logic        clk = 1'b0;
  logic        rstn;
  logic        stall;
  logic        reg_write_en;
  logic [4:0]  reg_write_addr;
  logic [31:0] reg_write_data;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        issue_valid;
  logic [4:0]  issue_dst;
  logic        rs_busy;
  logic        rt_busy;

  int n_cmp = 0;
  int n_err = 0;

  regfile dut (
    .clk            (clk),
    .rstn           (rstn),
    .stall          (stall),
    .reg_write_en   (reg_write_en),
    .reg_write_addr (reg_write_addr),
    .reg_write_data (reg_write_data),
    .rs_addr        (rs_addr),
    .rt_addr        (rt_addr),
    .rs_data        (rs_data),
    .rt_data        (rt_data),
    .issue_valid    (issue_valid),
    .issue_dst      (issue_dst),
    .rs_busy        (rs_busy),
    .rt_busy        (rt_busy)
  );

  always #5 clk = ~clk;

  task automatic idle();
    stall          = 1'b0;
    reg_write_en   = 1'b0;
    reg_write_addr = '0;
    reg_write_data = '0;
    issue_valid    = 1'b0;
    issue_dst      = '0;
  endtask

  // Inputs change on the falling edge; checks happen 1ns later.
  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    idle();
    rs_addr = 5'd5;
    rt_addr = 5'd31;
    #1;
    n_cmp++; if (rs_data !== 32'h0) begin n_err++; $display("FAIL reset_rs_data got %h want %h", rs_data, 32'h0); end
    n_cmp++; if (rt_data !== 32'h0) begin n_err++; $display("FAIL reset_rt_data got %h want %h", rt_data, 32'h0); end
    n_cmp++; if (rs_busy !== 1'b0) begin n_err++; $display("FAIL reset_rs_busy got %b want 0", rs_busy); end
    n_cmp++; if (rt_busy !== 1'b0) begin n_err++; $display("FAIL reset_rt_busy got %b want 0", rt_busy); end
    // write and issue during reset are lost
    @(negedge clk);
    reg_write_en = 1'b1; reg_write_addr = 5'd5; reg_write_data = 32'hCAFE0005;
    issue_valid = 1'b1; issue_dst = 5'd5;
    #1;
    n_cmp++; if (rs_data !== 32'h0) begin n_err++; $display("FAIL reset_bypass_rs got %h want %h", rs_data, 32'h0); end
    next_cycle();
    idle();
    rstn = 1'b1;
    #1;
    n_cmp++; if (rs_data !== 32'h0) begin n_err++; $display("FAIL reset_write_lost got %h want %h", rs_data, 32'h0); end
    n_cmp++; if (rs_busy !== 1'b0) begin n_err++; $display("FAIL reset_issue_lost got %b want 0", rs_busy); end
  endtask

  task automatic test_write_read();
    @(negedge clk);
    reg_write_en = 1'b1; reg_write_addr = 5'd0; reg_write_data = 32'hDEADBEEF;
    rs_addr = 5'd0; rt_addr = 5'd0;
    #1;
    n_cmp++; if (rs_data !== 32'h0) begin n_err++; $display("FAIL r0_same_cycle got %h want %h", rs_data, 32'h0); end
    next_cycle();
    idle();
    #1;
    n_cmp++; if (rs_data !== 32'h0) begin n_err++; $display("FAIL r0_read got %h want %h", rs_data, 32'h0); end
    n_cmp++; if (rs_busy !== 1'b0) begin n_err++; $display("FAIL r0_busy got %b want 0", rs_busy); end
    @(negedge clk);
    reg_write_en = 1'b1; reg_write_addr = 5'd7; reg_write_data = 32'h12345678;
    rs_addr = 5'd7; rt_addr = 5'd7;
    #1;
`ifdef REGFILE_BYPASS_EN
    n_cmp++; if (rt_data !== 32'h12345678) begin n_err++; $display("FAIL r7_write_cycle got %h want %h", rt_data, 32'h12345678); end
`else
    n_cmp++; if (rt_data !== 32'h0) begin n_err++; $display("FAIL r7_write_cycle got %h want %h", rt_data, 32'h0); end
`endif
    next_cycle();
    idle();
    #1;
    n_cmp++; if (rs_data !== 32'h12345678) begin n_err++; $display("FAIL r7_rs got %h want %h", rs_data, 32'h12345678); end
    n_cmp++; if (rt_data !== 32'h12345678) begin n_err++; $display("FAIL r7_rt got %h want %h", rt_data, 32'h12345678); end
  endtask

  task automatic test_scoreboard();
    @(negedge clk);
    issue_valid = 1'b1; issue_dst = 5'd9;
    rs_addr = 5'd9; rt_addr = 5'd9;
    #1;
    n_cmp++; if (rs_busy !== 1'b0) begin n_err++; $display("FAIL sb_issue_cycle got %b want 0", rs_busy); end
    next_cycle();
    idle();
    #1;
    n_cmp++; if (rs_busy !== 1'b1) begin n_err++; $display("FAIL sb_busy_rs got %b want 1", rs_busy); end
    n_cmp++; if (rt_busy !== 1'b1) begin n_err++; $display("FAIL sb_busy_rt got %b want 1", rt_busy); end
    next_cycle();
    #1;
    n_cmp++; if (rs_busy !== 1'b1) begin n_err++; $display("FAIL sb_busy_hold got %b want 1", rs_busy); end
    @(negedge clk);
    reg_write_en = 1'b1; reg_write_addr = 5'd9; reg_write_data = 32'hA5A5A5A5;
    #1;
`ifdef REGFILE_BYPASS_EN
    n_cmp++; if (rs_data !== 32'hA5A5A5A5) begin n_err++; $display("FAIL sb_wb_data got %h want %h", rs_data, 32'hA5A5A5A5); end
    n_cmp++; if (rs_busy !== 1'b0) begin n_err++; $display("FAIL sb_wb_busy got %b want 0", rs_busy); end
`else
    n_cmp++; if (rs_data !== 32'h0) begin n_err++; $display("FAIL sb_wb_data got %h want %h", rs_data, 32'h0); end
    n_cmp++; if (rs_busy !== 1'b1) begin n_err++; $display("FAIL sb_wb_busy got %b want 1", rs_busy); end
`endif
    next_cycle();
    idle();
    #1;
    n_cmp++; if (rs_data !== 32'hA5A5A5A5) begin n_err++; $display("FAIL sb_after_data got %h want %h", rs_data, 32'hA5A5A5A5); end
    n_cmp++; if (rs_busy !== 1'b0) begin n_err++; $display("FAIL sb_after_busy got %b want 0", rs_busy); end
  endtask

  task automatic test_same_cycle();
    @(negedge clk);
    issue_valid = 1'b1; issue_dst = 5'd4;
    reg_write_en = 1'b1; reg_write_addr = 5'd4; reg_write_data = 32'h1;
    rs_addr = 5'd4; rt_addr = 5'd6;
    next_cycle();
    idle();
    #1;
    n_cmp++; if (rs_data !== 32'h1) begin n_err++; $display("FAIL same_reg_data got %h want %h", rs_data, 32'h1); end
    n_cmp++; if (rs_busy !== 1'b1) begin n_err++; $display("FAIL same_reg_set_wins got %b want 1", rs_busy); end
    // set r6 and clear r4 at the same edge
    @(negedge clk);
    issue_valid = 1'b1; issue_dst = 5'd6;
    reg_write_en = 1'b1; reg_write_addr = 5'd4; reg_write_data = 32'h2;
    next_cycle();
    idle();
    #1;
    n_cmp++; if (rs_data !== 32'h2) begin n_err++; $display("FAIL diff_reg_data got %h want %h", rs_data, 32'h2); end
    n_cmp++; if (rs_busy !== 1'b0) begin n_err++; $display("FAIL diff_reg_clear got %b want 0", rs_busy); end
    n_cmp++; if (rt_busy !== 1'b1) begin n_err++; $display("FAIL diff_reg_set got %b want 1", rt_busy); end
    // write to a non-busy register commits and leaves busy clear
    @(negedge clk);
    reg_write_en = 1'b1; reg_write_addr = 5'd11; reg_write_data = 32'h0BADF00D;
    rs_addr = 5'd11;
    next_cycle();
    idle();
    #1;
    n_cmp++; if (rs_data !== 32'h0BADF00D) begin n_err++; $display("FAIL nonbusy_data got %h want %h", rs_data, 32'h0BADF00D); end
    n_cmp++; if (rs_busy !== 1'b0) begin n_err++; $display("FAIL nonbusy_busy got %b want 0", rs_busy); end
  endtask

  task automatic test_stall();
    @(negedge clk);
    stall = 1'b1;
    reg_write_en = 1'b1; reg_write_addr = 5'd3; reg_write_data = 32'hFF;
    issue_valid = 1'b1; issue_dst = 5'd3;
    rs_addr = 5'd3; rt_addr = 5'd7;
    #1;
    n_cmp++; if (rs_data !== 32'h0) begin n_err++; $display("FAIL stall_no_bypass got %h want %h", rs_data, 32'h0); end
    next_cycle();
    #1;
    n_cmp++; if (rs_data !== 32'h0) begin n_err++; $display("FAIL stall_data_held got %h want %h", rs_data, 32'h0); end
    n_cmp++; if (rs_busy !== 1'b0) begin n_err++; $display("FAIL stall_busy_held got %b want 0", rs_busy); end
    n_cmp++; if (rt_data !== 32'h12345678) begin n_err++; $display("FAIL stall_read_tracks got %h want %h", rt_data, 32'h12345678); end
    @(negedge clk);
    stall = 1'b0;
    next_cycle();
    idle();
    #1;
    n_cmp++; if (rs_data !== 32'hFF) begin n_err++; $display("FAIL unstall_data got %h want %h", rs_data, 32'hFF); end
    n_cmp++; if (rs_busy !== 1'b1) begin n_err++; $display("FAIL unstall_busy got %b want 1", rs_busy); end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    reg_write_en = 1'b1; reg_write_addr = 5'd10; reg_write_data = 32'h55;
    issue_valid = 1'b1; issue_dst = 5'd10;
    rs_addr = 5'd10; rt_addr = 5'd7;
    next_cycle();
    idle();
    #1;
    n_cmp++; if (rs_data !== 32'h55) begin n_err++; $display("FAIL pre_rst_data got %h want %h", rs_data, 32'h55); end
    n_cmp++; if (rs_busy !== 1'b1) begin n_err++; $display("FAIL pre_rst_busy got %b want 1", rs_busy); end
    #1;
    rstn = 1'b0;
    #1;
    n_cmp++; if (rs_data !== 32'h0) begin n_err++; $display("FAIL async_rst_data got %h want %h", rs_data, 32'h0); end
    n_cmp++; if (rs_busy !== 1'b0) begin n_err++; $display("FAIL async_rst_busy got %b want 0", rs_busy); end
    n_cmp++; if (rt_data !== 32'h0) begin n_err++; $display("FAIL async_rst_r7 got %h want %h", rt_data, 32'h0); end
    @(negedge clk);
    rstn = 1'b1;
    reg_write_en = 1'b1; reg_write_addr = 5'd12; reg_write_data = 32'h600DCAFE;
    issue_valid = 1'b1; issue_dst = 5'd13;
    rs_addr = 5'd12; rt_addr = 5'd13;
    next_cycle();
    idle();
    #1;
    n_cmp++; if (rs_data !== 32'h600DCAFE) begin n_err++; $display("FAIL post_rst_write got %h want %h", rs_data, 32'h600DCAFE); end
    n_cmp++; if (rt_busy !== 1'b1) begin n_err++; $display("FAIL post_rst_issue got %b want 1", rt_busy); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_scoreboard();
    test_same_cycle();
    test_stall();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
